// File: rtl/alu_operand_stage.sv
// Two-entry elastic operand buffer feeding the ALU 2:1 operand mux bank.
// Presents a registered (x, y, sel) head triple and counts completed output transfers.
module alu_operand_stage #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_x,
  output logic [WIDTH-1:0] out_y,
  output logic             out_sel,
  output logic [CNT_W-1:0] xfer_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] head_x_reg, head_y_reg;
  logic [WIDTH-1:0] tail_x_reg, tail_y_reg;
  logic             head_sel_reg, tail_sel_reg;
  logic [CNT_W-1:0] cnt_reg;

  logic push, pop;
  logic head_from_in, head_from_tail, tail_from_in;

  assign push = in_valid & in_ready;
  assign pop  = out_valid & out_ready;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= EMPTY;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state decode; also selects which data register loads from where.
  always_comb begin
    state_next     = state_reg;
    head_from_in   = 1'b0;
    head_from_tail = 1'b0;
    tail_from_in   = 1'b0;
    case (state_reg)
      EMPTY: begin
        if (push) begin
          head_from_in = 1'b1;
          state_next   = ONE;
        end
      end
      ONE: begin
        if (push && pop) begin
          head_from_in = 1'b1;
        end else if (push) begin
          tail_from_in = 1'b1;
          state_next   = FULL;
        end else if (pop) begin
          state_next = EMPTY;
        end
      end
      FULL: begin
        if (pop) begin
          head_from_tail = 1'b1;
          state_next     = ONE;
        end
      end
      default: state_next = EMPTY;
    endcase
  end

  // Data registers only load on a handshake, so idle input values never reach state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_x_reg   <= '0;
      head_y_reg   <= '0;
      head_sel_reg <= 1'b0;
      tail_x_reg   <= '0;
      tail_y_reg   <= '0;
      tail_sel_reg <= 1'b0;
    end else begin
      if (head_from_in) begin
        head_x_reg   <= in_a;
        head_y_reg   <= in_b;
        head_sel_reg <= in_sel;
      end else if (head_from_tail) begin
        head_x_reg   <= tail_x_reg;
        head_y_reg   <= tail_y_reg;
        head_sel_reg <= tail_sel_reg;
      end
      if (tail_from_in) begin
        tail_x_reg   <= in_a;
        tail_y_reg   <= in_b;
        tail_sel_reg <= in_sel;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg <= '0;
    end else if (pop) begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

  // Output decode from registered state only; in_ready never sees out_ready.
  always_comb begin
    in_ready  = (state_reg != FULL);
    out_valid = (state_reg != EMPTY);
    out_sel   = head_sel_reg & out_valid;
  end

  // Per bit-slice gating so the mux bank sees zeros when nothing is valid.
  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_slice
      assign out_x[gi] = head_x_reg[gi] & out_valid;
      assign out_y[gi] = head_y_reg[gi] & out_valid;
    end
  endgenerate

  assign xfer_cnt = cnt_reg;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Bench for alu_operand_stage: hand-derived vector table, directed corner sequences
// and randomized traffic, all checked against a queue-based reference model.
module tb_alu_operand_stage;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid, in_ready, in_sel;
  logic [7:0] in_a, in_b;
  logic       out_valid, out_ready, out_sel;
  logic [7:0] out_x, out_y, xfer_cnt;

  always #5 clk = ~clk;

  alu_operand_stage #(.WIDTH(8), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_sel(in_sel),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_x(out_x), .out_y(out_y), .out_sel(out_sel),
    .xfer_cnt(xfer_cnt)
  );

  typedef struct {
    logic        v;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        s;
    logic        ordy;
    logic [26:0] exp;
  } vec_t;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       s;
  } trip_t;

  trip_t       q[$];
  int unsigned cnt_m;
  int          n_checks = 0;
  int          n_fail = 0;
  vec_t        tbl[18];

  function automatic logic [26:0] pk(logic rdy, logic ov, logic [7:0] x, logic [7:0] y,
                                     logic sel, logic [7:0] c);
    return {rdy, ov, x, y, sel, c};
  endfunction

  function automatic logic [26:0] act();
    return {in_ready, out_valid, out_x, out_y, out_sel, xfer_cnt};
  endfunction

  // Expected outputs follow directly from the FIFO contents and the pop count.
  function automatic logic [26:0] model_exp();
    logic [7:0] c;
    c = 8'(cnt_m % 256);
    if (q.size() > 0) return pk(q.size() < 2, 1'b1, q[0].a, q[0].b, q[0].s, c);
    return pk(1'b1, 1'b0, 8'h00, 8'h00, 1'b0, c);
  endfunction

  function automatic vec_t row(logic v, logic [7:0] a, logic [7:0] b, logic s, logic ordy,
                               logic rdy, logic ov, logic [7:0] x, logic [7:0] y,
                               logic sel, logic [7:0] c);
    vec_t r;
    r.v = v; r.a = a; r.b = b; r.s = s; r.ordy = ordy;
    r.exp = pk(rdy, ov, x, y, sel, c);
    return r;
  endfunction

  task automatic check(string name, logic [26:0] got, logic [26:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got rdy/ov/x/y/sel/cnt=%b/%b/%h/%h/%b/%h required %b/%b/%h/%h/%b/%h",
               name, got[26], got[25], got[24:17], got[16:9], got[8], got[7:0],
               want[26], want[25], want[24:17], want[16:9], want[8], want[7:0]);
    end
  endtask

  // One clock cycle: drive after the falling edge, check, then let the model follow the rising edge.
  task automatic cycle(string name, logic v, logic [7:0] a, logic [7:0] b, logic s,
                       logic ordy, bit use_exp, logic [26:0] exp);
    bit    push_m, pop_m;
    trip_t t;
    in_valid = v; in_a = a; in_b = b; in_sel = s; out_ready = ordy;
    #1;
    check({name, "/model"}, act(), model_exp());
    if (use_exp) check({name, "/table"}, act(), exp);
    push_m = v && (q.size() < 2);
    pop_m  = (q.size() > 0) && ordy;
    @(posedge clk);
    if (pop_m) begin
      $display("xfer %0d: x=%h y=%h sel=%0b", cnt_m, q[0].a, q[0].b, q[0].s);
      void'(q.pop_front());
      cnt_m++;
    end
    if (push_m) begin
      t.a = a; t.b = b; t.s = s;
      q.push_back(t);
    end
    @(negedge clk);
  endtask

  // Asserts reset mid-cycle, well away from any rising edge.
  task automatic do_reset(string name);
    #2 rst_n = 1'b0;
    #1 check(name, act(), pk(1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00));
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    q.delete();
    cnt_m = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = row(1, 8'h3C, 8'hA5, 0, 1,  1, 0, 8'h00, 8'h00, 0, 8'd0);
    tbl[1]  = row(0, 8'h00, 8'h00, 0, 1,  1, 1, 8'h3C, 8'hA5, 0, 8'd0);
    tbl[2]  = row(0, 8'h00, 8'h00, 0, 1,  1, 0, 8'h00, 8'h00, 0, 8'd1);
    tbl[3]  = row(1, 8'h11, 8'h22, 1, 0,  1, 0, 8'h00, 8'h00, 0, 8'd1);
    tbl[4]  = row(1, 8'h33, 8'h44, 0, 0,  1, 1, 8'h11, 8'h22, 1, 8'd1);
    tbl[5]  = row(1, 8'h55, 8'h66, 1, 0,  0, 1, 8'h11, 8'h22, 1, 8'd1);
    tbl[6]  = row(1, 8'h55, 8'h66, 1, 0,  0, 1, 8'h11, 8'h22, 1, 8'd1);
    tbl[7]  = row(1, 8'h55, 8'h66, 1, 1,  0, 1, 8'h11, 8'h22, 1, 8'd1);
    tbl[8]  = row(1, 8'h55, 8'h66, 1, 1,  1, 1, 8'h33, 8'h44, 0, 8'd2);
    tbl[9]  = row(0, 8'h00, 8'h00, 0, 1,  1, 1, 8'h55, 8'h66, 1, 8'd3);
    tbl[10] = row(0, 8'h00, 8'h00, 0, 1,  1, 0, 8'h00, 8'h00, 0, 8'd4);
    tbl[11] = row(1, 8'h01, 8'hF1, 1, 1,  1, 0, 8'h00, 8'h00, 0, 8'd4);
    tbl[12] = row(1, 8'h02, 8'hF2, 0, 1,  1, 1, 8'h01, 8'hF1, 1, 8'd4);
    tbl[13] = row(1, 8'h03, 8'hF3, 1, 1,  1, 1, 8'h02, 8'hF2, 0, 8'd5);
    tbl[14] = row(1, 8'h04, 8'hF4, 0, 1,  1, 1, 8'h03, 8'hF3, 1, 8'd6);
    tbl[15] = row(1, 8'h05, 8'hF5, 1, 1,  1, 1, 8'h04, 8'hF4, 0, 8'd7);
    tbl[16] = row(0, 8'h00, 8'h00, 0, 1,  1, 1, 8'h05, 8'hF5, 1, 8'd8);
    tbl[17] = row(0, 8'h00, 8'h00, 0, 1,  1, 0, 8'h00, 8'h00, 0, 8'd9);

    in_valid = 1'b0; in_a = '0; in_b = '0; in_sel = 1'b0; out_ready = 1'b0;
    cnt_m = 0;
    #2 check("reset", act(), pk(1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00));
    @(negedge clk);
    rst_n = 1'b1;

    // Single push, backpressure, and sustained push+pop in ONE
    for (int i = 0; i < 18; i++)
      cycle($sformatf("row%0d", i), tbl[i].v, tbl[i].a, tbl[i].b, tbl[i].s, tbl[i].ordy,
            1'b1, tbl[i].exp);

    // Back-to-back streaming of 16 triples
    for (int i = 0; i < 16; i++) begin
      logic [7:0] iv;
      iv = 8'(i);
      cycle("stream", 1'b1, iv, ~iv, iv[0], 1'b1, 1'b0, '0);
    end
    cycle("stream_drain", 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, '0);
    #1 check("stream_cnt", {19'd0, xfer_cnt}, {19'd0, 8'd25});

    // Randomized traffic against the queue model
    for (int i = 0; i < 400; i++)
      cycle("rand", 1'($urandom_range(0, 3) != 0), 8'($urandom), 8'($urandom),
            1'($urandom), 1'($urandom_range(0, 2) != 0), 1'b0, '0);

    // Counter wrap after 257 pops
    do_reset("wrap_reset");
    for (int i = 0; i < 257; i++)
      cycle("wrap", 1'b1, 8'(i), 8'(i + 3), 1'(i), 1'b1, 1'b0, '0);
    cycle("wrap_drain", 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, '0);
    #1 check("wrap_cnt", {19'd0, xfer_cnt}, {19'd0, 8'd1});

    // Asynchronous reset while FULL
    cycle("fill0", 1'b1, 8'hA1, 8'hB1, 1'b1, 1'b0, 1'b0, '0);
    cycle("fill1", 1'b1, 8'hA2, 8'hB2, 1'b0, 1'b0, 1'b0, '0);
    #1 check("full", act(), pk(1'b0, 1'b1, 8'hA1, 8'hB1, 1'b1, 8'd1));
    do_reset("async_reset");
    cycle("post_rst0", 1'b1, 8'h07, 8'h09, 1'b1, 1'b1, 1'b1,
          pk(1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 8'd0));
    cycle("post_rst1", 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b1,
          pk(1'b1, 1'b1, 8'h07, 8'h09, 1'b1, 8'd0));
    cycle("post_rst2", 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b1,
          pk(1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 8'd1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
